// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and decode-side resolve.
// Optional global-history index hashing is enabled with `define BP_GSHARE_EN.
module branch_predictor #(
    parameter int IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_f,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        branch_d,
    input  logic [31:0] pc_d,
    input  logic        taken_d,
    input  logic [31:0] target_d,
    output logic        predict_taken_f,
    output logic [31:0] predict_target_f,
    output logic        mispredict_d,
    output logic [31:0] redirect_pc_d
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [IDX_BITS-1:0] idx_f;
    logic                hit_f;
    logic                resolve;
    logic [1:0]          ctr_next;

    logic                dec_taken_q, dec_taken_d;
    logic                dec_hit_q, dec_hit_d;
    logic [31:0]         dec_target_q, dec_target_d;
    logic [IDX_BITS-1:0] dec_idx_q, dec_idx_d;

    // Fetch stalls are absorbed upstream; the predictor only follows decode.
    logic unused_stall_f;
    assign unused_stall_f = stall_f;

`ifdef BP_GSHARE_EN
    logic [IDX_BITS-1:0] ghr_q, ghr_d;

    assign idx_f = pc_f[2+IDX_BITS-1:2] ^ ghr_q;
    assign ghr_d = resolve ? {ghr_q[IDX_BITS-2:0], taken_d} : ghr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ghr_q <= '0;
        else          ghr_q <= ghr_d;
    end
`else
    assign idx_f = pc_f[2+IDX_BITS-1:2];
`endif

    assign hit_f            = valid_q[idx_f] && (tag_q[idx_f] == pc_f[31:2+IDX_BITS]);
    assign predict_taken_f  = hit_f & ctr_q[idx_f][1];
    assign predict_target_f = predict_taken_f ? target_q[idx_f] : pc_f + 32'd4;

    assign resolve       = branch_d & ~stall_d;
    // A non-branch carrying a taken prediction means an aliased tag hit redirected fetch.
    assign mispredict_d  = (resolve & (dec_taken_q != taken_d))
                         | (resolve & taken_d & dec_taken_q & (dec_target_q != target_d))
                         | (~branch_d & ~stall_d & dec_taken_q);
    assign redirect_pc_d = (branch_d & taken_d) ? target_d : pc_d + 32'd4;

    always_comb begin
        dec_taken_d  = dec_taken_q;
        dec_hit_d    = dec_hit_q;
        dec_target_d = dec_target_q;
        dec_idx_d    = dec_idx_q;
        if (!stall_d) begin
            if (mispredict_d) begin
                dec_taken_d  = 1'b0;
                dec_hit_d    = 1'b0;
                dec_target_d = '0;
                dec_idx_d    = '0;
            end else begin
                dec_taken_d  = predict_taken_f;
                dec_hit_d    = hit_f;
                dec_target_d = predict_target_f;
                dec_idx_d    = idx_f;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_taken_q  <= 1'b0;
            dec_hit_q    <= 1'b0;
            dec_target_q <= '0;
            dec_idx_q    <= '0;
        end else begin
            dec_taken_q  <= dec_taken_d;
            dec_hit_q    <= dec_hit_d;
            dec_target_q <= dec_target_d;
            dec_idx_q    <= dec_idx_d;
        end
    end

    always_comb begin
        ctr_next = ctr_q[dec_idx_q];
        if (taken_d) begin
            if (ctr_q[dec_idx_q] != 2'b11) ctr_next = ctr_q[dec_idx_q] + 2'b01;
        end else begin
            if (ctr_q[dec_idx_q] != 2'b00) ctr_next = ctr_q[dec_idx_q] - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (resolve) begin
            if (dec_hit_q) begin
                ctr_q[dec_idx_q] <= ctr_next;
                if (taken_d) target_q[dec_idx_q] <= target_d;
            end else if (taken_d) begin
                valid_q[dec_idx_q]  <= 1'b1;
                tag_q[dec_idx_q]    <= pc_d[31:2+IDX_BITS];
                target_q[dec_idx_q] <= target_d;
                ctr_q[dec_idx_q]    <= 2'b10;
            end
        end
    end
endmodule
